// File: rtl/match_result_fsm.sv
// match_result_fsm: two-innings match controller.
// Tracks innings 1, the innings break and innings 2, ends the match early
// when the chasing side passes the target, and latches winner, margin and
// a one-cycle result strobe.
// Optional feature macro: TIE_BREAK_WKTS_EN (on equal runs, the side with
// fewer wickets lost wins by the wicket difference).
module match_result_fsm #(
    parameter int MAX_BALLS   = 120,
    parameter int MAX_WICKETS = 10,
    parameter int RUN_W       = 8,
    parameter int BALL_W      = 7,
    parameter int WKT_W       = 4
) (
    input  logic              clk_fpga,
    input  logic              reset,
    input  logic [RUN_W-1:0]  team1_runs,
    input  logic [WKT_W-1:0]  team1_wkts,
    input  logic [BALL_W-1:0] team1_balls,
    input  logic [RUN_W-1:0]  team2_runs,
    input  logic [WKT_W-1:0]  team2_wkts,
    input  logic [BALL_W-1:0] team2_balls,
    input  logic              next_inning,
    output logic              batting_team,
    output logic              inning_over,
    output logic              game_over,
    output logic [1:0]        winner,
    output logic [RUN_W-1:0]  margin,
    output logic              result_valid,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        INN1  = 2'b00,
        BREAK = 2'b01,
        INN2  = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_T1   = 2'b01;
    localparam logic [1:0] WIN_T2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    // Limits brought to the width of the counters they are compared with.
    localparam logic [WKT_W-1:0]  MAX_WKTS_L  = WKT_W'(MAX_WICKETS);
    localparam logic [BALL_W-1:0] MAX_BALLS_L = BALL_W'(MAX_BALLS);

    // Run difference, clamped at zero so a negative result never escapes.
    function automatic logic [RUN_W-1:0] run_diff(input logic [RUN_W-1:0] a,
                                                  input logic [RUN_W-1:0] b);
        return (a >= b) ? (a - b) : '0;
    endfunction

    // Wicket difference, clamped at zero and zero-extended to run width.
    function automatic logic [RUN_W-1:0] wkt_diff(input logic [WKT_W-1:0] hi,
                                                  input logic [WKT_W-1:0] lo);
        logic [WKT_W-1:0] d;
        d = (hi >= lo) ? (hi - lo) : '0;
        return RUN_W'(d);
    endfunction

    state_t             state_q, state_d;
    logic               batting_team_q, batting_team_d;
    logic               inning_over_q, inning_over_d;
    logic               game_over_q, game_over_d;
    logic [1:0]         winner_q, winner_d;
    logic [RUN_W-1:0]   margin_q, margin_d;
    logic               result_valid_q, result_valid_d;

    logic done1, done2, chase;

    // Innings-complete and chase conditions from the live score inputs.
    always_comb begin
        done1 = (team1_wkts >= MAX_WKTS_L) || (team1_balls >= MAX_BALLS_L);
        done2 = (team2_wkts >= MAX_WKTS_L) || (team2_balls >= MAX_BALLS_L);
        chase = (team2_runs > team1_runs);
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d        = state_q;
        batting_team_d = batting_team_q;
        inning_over_d  = inning_over_q;
        game_over_d    = game_over_q;
        winner_d       = winner_q;
        margin_d       = margin_q;
        result_valid_d = 1'b0;

        unique case (state_q)
            INN1: begin
                batting_team_d = 1'b0;
                if (done1) begin
                    state_d       = BREAK;
                    inning_over_d = 1'b1;
                end
            end
            BREAK: begin
                inning_over_d = 1'b1;
                if (next_inning) begin
                    state_d        = INN2;
                    inning_over_d  = 1'b0;
                    batting_team_d = 1'b1;
                end
            end
            INN2: begin
                // Chase is tested first so that passing the target on the
                // last ball is still a team 2 win.
                if (chase) begin
                    state_d        = DONE;
                    winner_d       = WIN_T2;
                    margin_d       = wkt_diff(MAX_WKTS_L, team2_wkts);
                    inning_over_d  = 1'b1;
                    game_over_d    = 1'b1;
                    result_valid_d = 1'b1;
                end else if (done2) begin
                    state_d        = DONE;
                    inning_over_d  = 1'b1;
                    game_over_d    = 1'b1;
                    result_valid_d = 1'b1;
                    if (team1_runs > team2_runs) begin
                        winner_d = WIN_T1;
                        margin_d = run_diff(team1_runs, team2_runs);
                    end else begin
`ifdef TIE_BREAK_WKTS_EN
                        if (team1_wkts < team2_wkts) begin
                            winner_d = WIN_T1;
                            margin_d = wkt_diff(team2_wkts, team1_wkts);
                        end else if (team2_wkts < team1_wkts) begin
                            winner_d = WIN_T2;
                            margin_d = wkt_diff(team1_wkts, team2_wkts);
                        end else begin
                            winner_d = WIN_TIE;
                            margin_d = '0;
                        end
`else
                        winner_d = WIN_TIE;
                        margin_d = '0;
`endif
                    end
                end
            end
            DONE: begin
                // Absorbing: result held until reset.
                state_d = DONE;
            end
            default: state_d = INN1;
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            state_q        <= INN1;
            batting_team_q <= 1'b0;
            inning_over_q  <= 1'b0;
            game_over_q    <= 1'b0;
            winner_q       <= WIN_NONE;
            margin_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            batting_team_q <= batting_team_d;
            inning_over_q  <= inning_over_d;
            game_over_q    <= game_over_d;
            winner_q       <= winner_d;
            margin_q       <= margin_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign state        = state_q;
    assign batting_team = batting_team_q;
    assign inning_over  = inning_over_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;
    assign margin       = margin_q;
    assign result_valid = result_valid_q;

endmodule
